axi_read_arbiter: RTL and testbench



---
 rtl/axi_read_arbiter.sv | 134 +++++++++++++
 tb/tb_axi_read_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/axi_read_arbiter.sv
// Round-robin arbiter sharing one AXI read port between the I-cache and D-cache refill engines.
// One burst in flight at a time; R beats are steered to the owner until rlast.
module axi_read_arbiter #(
  parameter int          BURST_LEN = 16,
  parameter logic [3:0]  INST_ID   = 4'h0,
  parameter logic [3:0]  DATA_ID   = 4'h1
) (
  input  logic        aclk,
  input  logic        aresetn,

  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_arready,
  output logic [31:0] inst_rdata,
  output logic        inst_rvalid,
  output logic        inst_rlast,

  input  logic        data_req,
  input  logic [31:0] data_addr,
  output logic        data_arready,
  output logic [31:0] data_rdata,
  output logic        data_rvalid,
  output logic        data_rlast,

  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,

  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  localparam int CNT_W = $clog2(BURST_LEN + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA
  } state_e;

  state_e           state_q;
  logic             owner_q;       // 0 = instruction, 1 = data
  logic             last_owner_q;
  logic [31:0]      araddr_q;
  logic [3:0]       arid_q;
  logic [CNT_W-1:0] beat_cnt_q;

  logic       grant_data;
  logic [3:0] owner_id;
  logic       beat_fwd;
  logic       ar_hs;

  // On a tie the requester that lost last time wins.
  assign grant_data = data_req & (~inst_req | ~last_owner_q);
  assign owner_id   = owner_q ? DATA_ID : INST_ID;
  assign beat_fwd   = (state_q == S_DATA) & rvalid & (rid == owner_id);
  assign ar_hs      = (state_q == S_ADDR) & arready;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      araddr_q     <= '0;
      arid_q       <= '0;
      beat_cnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (inst_req | data_req) begin
            owner_q  <= grant_data;
            araddr_q <= grant_data ? data_addr : inst_addr;
            arid_q   <= grant_data ? DATA_ID : INST_ID;
            state_q  <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (arready) begin
            beat_cnt_q <= '0;
            state_q    <= S_DATA;
          end
        end
        S_DATA: begin
          if (beat_fwd) begin
            if (beat_cnt_q != CNT_W'(BURST_LEN)) beat_cnt_q <= beat_cnt_q + CNT_W'(1);
            // Burst termination follows rlast; the counter is only a diagnostic.
            if (rlast) begin
              last_owner_q <= owner_q;
              state_q      <= S_IDLE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign arid    = arid_q;
  assign araddr  = araddr_q;
  assign arlen   = 8'(BURST_LEN - 1);
  assign arsize  = 3'b010;
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;
  assign arvalid = (state_q == S_ADDR);
  assign rready  = (state_q == S_DATA);

  assign inst_arready = ar_hs & ~owner_q;
  assign data_arready = ar_hs & owner_q;

  assign inst_rvalid = beat_fwd & ~owner_q;
  assign inst_rlast  = inst_rvalid & rlast;
  assign inst_rdata  = inst_rvalid ? rdata : '0;

  assign data_rvalid = beat_fwd & owner_q;
  assign data_rlast  = data_rvalid & rlast;
  assign data_rdata  = data_rvalid ? rdata : '0;

  logic unused_ok;
  assign unused_ok = ^{rresp, beat_cnt_q};

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Randomized bench for axi_read_arbiter: random requesters and AXI slave, checked every cycle
// against a burst-level reference model of the arbitration rules.
module tb_axi_read_arbiter;

  localparam int         BURST_LEN = 16;
  localparam logic [3:0] INST_ID   = 4'h0;
  localparam logic [3:0] DATA_ID   = 4'h1;
  localparam int         N_CYCLES  = 4000;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        inst_req, data_req;
  logic [31:0] inst_addr, data_addr;
  logic        inst_arready, data_arready;
  logic [31:0] inst_rdata, data_rdata;
  logic        inst_rvalid, inst_rlast, data_rvalid, data_rlast;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;

  axi_read_arbiter #(.BURST_LEN(BURST_LEN), .INST_ID(INST_ID), .DATA_ID(DATA_ID)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_arready(inst_arready),
    .inst_rdata(inst_rdata), .inst_rvalid(inst_rvalid), .inst_rlast(inst_rlast),
    .data_req(data_req), .data_addr(data_addr), .data_arready(data_arready),
    .data_rdata(data_rdata), .data_rvalid(data_rvalid), .data_rlast(data_rlast),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_flags"},
             64'({arvalid, rready, inst_arready, data_arready,
                  inst_rvalid, inst_rlast, data_rvalid, data_rlast}), 64'h0);
    check_eq({tag, "_araddr"}, 64'(araddr), 64'h0);
    check_eq({tag, "_arid"}, 64'(arid), 64'h0);
    check_eq({tag, "_rdata"}, 64'({inst_rdata, data_rdata}), 64'h0);
    check_eq({tag, "_arconst"}, 64'({arlen, arsize, arburst, arlock, arcache, arprot}),
             64'({8'(BURST_LEN - 1), 3'b010, 2'b01, 2'b00, 4'b0000, 3'b000}));
  endtask

  // Reference model: one burst record plus the round-robin memory.
  bit          m_busy, m_arp;
  int          m_own, m_last;
  logic [31:0] m_addr;

  bit          i_req_v, d_req_v;
  logic [31:0] i_addr_v, d_addr_v;

  bit          s_ireq, s_dreq, s_arready, s_rvalid, s_rlast, s_iarr, s_darr, s_fwd;
  logic [31:0] s_iaddr, s_daddr;
  logic [3:0]  s_rid;
  bit          o_arvalid, o_rready;
  logic [3:0]  o_arid;

  bit          sl_act;
  int          sl_left;
  logic [3:0]  sl_id;

  int          bursts = 0;
  bit          rst_done = 0;

  task automatic clear_stored();
    s_ireq = 0; s_dreq = 0; s_arready = 0; s_rvalid = 0; s_rlast = 0;
    s_iarr = 0; s_darr = 0; s_fwd = 0; s_iaddr = '0; s_daddr = '0; s_rid = '0;
    o_arvalid = 0; o_rready = 0; o_arid = '0;
  endtask

  task automatic drive_idle();
    inst_req = 0; data_req = 0; inst_addr = '0; data_addr = '0;
    arready = 0; rvalid = 0; rid = '0; rdata = '0; rlast = 0; rresp = '0;
  endtask

  initial begin
    bit          e_arv, e_rr, e_iarr, e_darr, fwd;
    logic [3:0]  own_id;
    logic [33:0] e_i, e_d;

    drive_idle();
    aresetn = 1'b0;
    m_busy = 0; m_arp = 0; m_own = 0; m_last = 1; m_addr = '0;
    sl_act = 0; sl_left = 0; sl_id = '0;
    clear_stored();
    #1;
    check_quiet("reset");
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;

    // Both requesters start high so the first tie is exercised.
    i_req_v = 1; i_addr_v = 32'hBFC0_0000;
    d_req_v = 1; d_addr_v = 32'h8000_1000;

    for (int cyc = 0; cyc < N_CYCLES; cyc++) begin
      if (!m_busy) begin
        if (s_ireq || s_dreq) begin
          m_own  = (s_ireq && s_dreq) ? ((m_last == 1) ? 0 : 1) : (s_ireq ? 0 : 1);
          m_addr = (m_own == 1) ? s_daddr : s_iaddr;
          m_busy = 1;
          m_arp  = 1;
        end
      end else if (m_arp) begin
        if (s_arready) m_arp = 0;
      end else if (s_fwd && s_rlast) begin
        m_busy = 0;
        m_last = m_own;
        bursts++;
      end

      if (o_arvalid && s_arready) begin
        sl_act = 1; sl_left = BURST_LEN; sl_id = o_arid;
      end else if (sl_act && s_rvalid && o_rready && s_rid == sl_id) begin
        sl_left--;
        if (sl_left == 0) sl_act = 0;
      end

      if (s_iarr) i_req_v = 0;
      else if (i_req_v && m_busy && m_arp && m_own == 0 && $urandom_range(0, 15) == 0) i_req_v = 0;
      else if (!i_req_v && $urandom_range(0, 3) == 0) begin
        i_req_v = 1; i_addr_v = $urandom & 32'hFFFF_FFFC;
      end
      if (s_darr) d_req_v = 0;
      else if (d_req_v && m_busy && m_arp && m_own == 1 && $urandom_range(0, 15) == 0) d_req_v = 0;
      else if (!d_req_v && $urandom_range(0, 3) == 0) begin
        d_req_v = 1; d_addr_v = $urandom & 32'hFFFF_FFFC;
      end

      inst_req = i_req_v; inst_addr = i_addr_v;
      data_req = d_req_v; data_addr = d_addr_v;
      arready = ($urandom_range(0, 1) == 1);
      rresp = 2'($urandom_range(0, 3));
      rdata = $urandom;
      rid = 4'($urandom_range(0, 15));
      rvalid = 0;
      rlast = 0;
      if (sl_act) begin
        if ($urandom_range(0, 3) != 0) begin
          rvalid = 1;
          if ($urandom_range(0, 7) == 0) begin
            rid = 4'h2;
            rlast = ($urandom_range(0, 1) == 1);
          end else begin
            rid = sl_id;
            rlast = (sl_left == 1);
          end
        end
      end else if ($urandom_range(0, 7) == 0) begin
        rvalid = 1;
        rlast = ($urandom_range(0, 1) == 1);
      end

      #1;
      e_arv  = m_busy && m_arp;
      e_rr   = m_busy && !m_arp;
      e_iarr = e_arv && arready && m_own == 0;
      e_darr = e_arv && arready && m_own == 1;
      own_id = (m_own == 1) ? DATA_ID : INST_ID;
      fwd    = e_rr && rvalid && (rid == own_id);
      e_i    = (fwd && m_own == 0) ? {1'b1, rlast, rdata} : 34'h0;
      e_d    = (fwd && m_own == 1) ? {1'b1, rlast, rdata} : 34'h0;

      check_eq("arvalid", 64'(arvalid), 64'(e_arv));
      if (e_arv) begin
        check_eq("araddr", 64'(araddr), 64'(m_addr));
        check_eq("arid", 64'(arid), 64'(own_id));
      end
      check_eq("rready", 64'(rready), 64'(e_rr));
      check_eq("inst_arready", 64'(inst_arready), 64'(e_iarr));
      check_eq("data_arready", 64'(data_arready), 64'(e_darr));
      check_eq("inst_r", 64'({inst_rvalid, inst_rlast, inst_rdata}), 64'(e_i));
      check_eq("data_r", 64'({data_rvalid, data_rlast, data_rdata}), 64'(e_d));

      s_ireq = inst_req; s_dreq = data_req; s_iaddr = inst_addr; s_daddr = data_addr;
      s_arready = arready; s_rvalid = rvalid; s_rlast = rlast; s_rid = rid;
      s_iarr = e_iarr; s_darr = e_darr; s_fwd = fwd;
      o_arvalid = arvalid; o_rready = rready; o_arid = arid;

      // Abort a data-phase burst partway through with an asynchronous reset.
      if (!rst_done && cyc > N_CYCLES / 2 && m_busy && !m_arp && sl_act &&
          sl_left <= BURST_LEN - 7) begin
        #2 aresetn = 1'b0;
        #1;
        check_quiet("midreset");
        rst_done = 1;
        drive_idle();
        m_busy = 0; m_arp = 0; m_last = 1;
        sl_act = 0; sl_left = 0;
        clear_stored();
        i_req_v = 0; d_req_v = 0;
        @(negedge aclk);
        aresetn = 1'b1;
        i_req_v = 1; i_addr_v = 32'hBFC0_0040;
      end

      @(negedge aclk);
    end

    check_eq("midreset_hit", 64'(rst_done), 64'h1);
    check_eq("progress", 64'(bursts > 20), 64'h1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
